// File: rtl/wb_interconnect_nslv.sv
// ---------------------------------------------------------------------------
// wb_interconnect_nslv
//   Single-master, NUM_SLV-slave Wishbone classic interconnect. The master
//   address is decoded against a per-slave base/mask map in IDLE, and the
//   selected slave is then connected to the master until it ACKs. The master
//   can abort by dropping CYC. A miss returns a one-cycle ERR. A slave that
//   does not ACK within TIMEOUT_CYC cycles is cut off and ERR is returned.
//   Errors are counted (saturating) and the faulting address is kept.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   M_ADR_O/DAT_O/WE_O/
//   M_SEL_O/STB_O/CYC_O      master request inputs
//   M_DAT_I/ACK_I/ERR_I      master response outputs
//   S_DAT_I/ADR_I/WE_I/
//   S_SEL_I/STB_I/CYC_I      packed per-slave request outputs
//   S_DAT_O/ACK_O            packed per-slave response inputs
//   err_cnt_o                saturating error count
//   err_addr_o               address of the most recent error
// ---------------------------------------------------------------------------
module wb_interconnect_nslv #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [ADDR_WIDTH-1:0]             M_ADR_O,
  input  logic [DATA_WIDTH-1:0]             M_DAT_O,
  input  logic                              M_WE_O,
  input  logic [DATA_WIDTH/8-1:0]           M_SEL_O,
  input  logic                              M_STB_O,
  input  logic                              M_CYC_O,
  output logic [DATA_WIDTH-1:0]             M_DAT_I,
  output logic                              M_ACK_I,
  output logic                              M_ERR_I,
  output logic [NUM_SLV*DATA_WIDTH-1:0]     S_DAT_I,
  output logic [NUM_SLV*ADDR_WIDTH-1:0]     S_ADR_I,
  output logic [NUM_SLV-1:0]                S_WE_I,
  output logic [NUM_SLV*DATA_WIDTH/8-1:0]   S_SEL_I,
  output logic [NUM_SLV-1:0]                S_STB_I,
  output logic [NUM_SLV-1:0]                S_CYC_I,
  input  logic [NUM_SLV*DATA_WIDTH-1:0]     S_DAT_O,
  input  logic [NUM_SLV-1:0]                S_ACK_O,
  output logic [7:0]                        err_cnt_o,
  output logic [ADDR_WIDTH-1:0]             err_addr_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DECERR = 2'd2;

  logic [1:0]       state;
  logic [SEL_W-1:0] sel_q;
  logic [WD_W-1:0]  wdog;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_idx;
  logic             active;
  logic             ack_sel;
  logic             abort;
  logic             wd_fire;
  logic             log_err;

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((M_ADR_O & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLV_BASE[k*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(k);
      end
    end
  end

  assign active  = (state == ACTIVE);
  assign ack_sel = active & S_ACK_O[sel_q];
  assign abort   = active & ~M_CYC_O;
  // ACK on the last watchdog cycle takes precedence over the timeout, and an
  // aborting master (CYC low) never gets an error.
  assign wd_fire = WD_EN & active & M_CYC_O & ~ack_sel & (wdog == WD_LAST);
  assign log_err = wd_fire | (state == DECERR);

  // Routing: only the latched slave is driven, and only while ACTIVE.
  always_comb begin
    S_DAT_I = '0;
    S_ADR_I = '0;
    S_WE_I  = '0;
    S_SEL_I = '0;
    S_STB_I = '0;
    S_CYC_I = '0;
    M_DAT_I = '0;
    M_ACK_I = 1'b0;
    M_ERR_I = 1'b0;
    if (active) begin
      S_DAT_I[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH] = M_DAT_O;
      S_ADR_I[32'(sel_q)*ADDR_WIDTH +: ADDR_WIDTH] = M_ADR_O;
      S_SEL_I[32'(sel_q)*BE_W +: BE_W]             = M_SEL_O;
      S_WE_I[sel_q]  = M_WE_O;
      // On timeout the slave is released in the same cycle ERR goes out.
      S_STB_I[sel_q] = M_STB_O & ~wd_fire;
      S_CYC_I[sel_q] = M_CYC_O & ~wd_fire;
      M_DAT_I = S_DAT_O[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
      M_ACK_I = ack_sel;
      M_ERR_I = wd_fire;
    end else if (state == DECERR) begin
      M_ERR_I = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      sel_q      <= '0;
      wdog       <= '0;
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (M_STB_O && M_CYC_O) begin
            if (dec_hit) begin
              sel_q <= dec_idx;
              wdog  <= '0;
              state <= ACTIVE;
            end else begin
              state <= DECERR;
            end
          end
        end
        ACTIVE: begin
          if (ack_sel || abort || wd_fire) begin
            state <= IDLE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        DECERR:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (log_err) begin
        if (err_cnt_o != 8'hFF) begin
          err_cnt_o <= err_cnt_o + 8'd1;
        end
        err_addr_o <= M_ADR_O;
      end
    end
  end

endmodule
